player_ctrl: RTL and testbench

- Upstream stage of the laser renderer. Converts raw player buttons into the player position (player_x, player_y) and the laser enable (shooting) that the laser and sprite layers consume.
- Contains its own frame-rate tick generator, 2-flop button synchronisers, a clamped position integrator, and a laser energy/cooldown FSM.
- All coordinates are playfield-relative, origin at the top-left of the 384x448 field.

---
 rtl/player_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_player_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/player_ctrl.sv
// player_ctrl: frame-tick generator, button synchronisers, clamped position integrator and laser energy FSM.
// Optional build macro FOCUS_SLOW_EN: btn_slow selects SLOW_SPEED as the per-tick step.
module player_ctrl #(
    parameter int MAX_X       = 384,
    parameter int MAX_Y       = 448,
    parameter int START_X     = 192,
    parameter int START_Y     = 400,
    parameter int MARGIN      = 8,
    parameter int SPEED       = 4,
    parameter int SLOW_SPEED  = 2,
    parameter int TICK_MAX    = 1666666,
    parameter int FIRE_MAX    = 120,
    parameter int COOL_FRAMES = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_fire,
    input  logic       btn_slow,
    output logic [9:0] player_x,
    output logic [9:0] player_y,
    output logic       shooting,
    output logic [7:0] energy,
    output logic       frame_tick
);
    localparam int TW = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
    localparam int CW = (COOL_FRAMES > 0) ? $clog2(COOL_FRAMES + 1) : 1;

    localparam int B_UP    = 0;
    localparam int B_DOWN  = 1;
    localparam int B_LEFT  = 2;
    localparam int B_RIGHT = 3;
    localparam int B_FIRE  = 4;
    localparam int B_SLOW  = 5;

    localparam logic signed [10:0] X_LO = 11'(MARGIN);
    localparam logic signed [10:0] X_HI = 11'(MAX_X - MARGIN - 1);
    localparam logic signed [10:0] Y_LO = 11'(MARGIN);
    localparam logic signed [10:0] Y_HI = 11'(MAX_Y - MARGIN - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FIRING   = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [5:0]         raw_btn;
    logic [5:0]         sync1_q, sync1_d;
    logic [5:0]         sync2_q, sync2_d;
    logic [TW-1:0]      tick_q, tick_d;
    logic [9:0]         x_q, x_d;
    logic [9:0]         y_q, y_d;
    logic [7:0]         energy_q, energy_d;
    logic [CW-1:0]      cool_q, cool_d;
    logic               shooting_q, shooting_d;
    logic               tick;
    logic               up, down, left, right, fire;
    logic signed [10:0] step, nx, ny;

    assign raw_btn = {btn_slow, btn_fire, btn_right, btn_left, btn_down, btn_up};
    assign tick    = (tick_q == TW'(TICK_MAX));
    assign up      = sync2_q[B_UP];
    assign down    = sync2_q[B_DOWN];
    assign left    = sync2_q[B_LEFT];
    assign right   = sync2_q[B_RIGHT];
    assign fire    = sync2_q[B_FIRE];

`ifndef FOCUS_SLOW_EN
    logic unused_slow;
    assign unused_slow = sync2_q[B_SLOW];
`endif

    always_comb begin
        sync1_d = raw_btn;
        sync2_d = sync1_q;
        tick_d  = tick ? '0 : tick_q + TW'(1);
    end

    // Opposing buttons cancel; the result is clamped so the player never wraps past an edge.
    always_comb begin
        step = 11'(SPEED);
`ifdef FOCUS_SLOW_EN
        if (sync2_q[B_SLOW]) begin
            step = 11'(SLOW_SPEED);
        end
`endif
        nx = $signed({1'b0, x_q});
        ny = $signed({1'b0, y_q});
        if (left && !right) begin
            nx = nx - step;
        end else if (right && !left) begin
            nx = nx + step;
        end
        if (up && !down) begin
            ny = ny - step;
        end else if (down && !up) begin
            ny = ny + step;
        end
        if (nx < X_LO) begin
            nx = X_LO;
        end else if (nx > X_HI) begin
            nx = X_HI;
        end
        if (ny < Y_LO) begin
            ny = Y_LO;
        end else if (ny > Y_HI) begin
            ny = Y_HI;
        end
        x_d = tick ? nx[9:0] : x_q;
        y_d = tick ? ny[9:0] : y_q;
    end

    always_comb begin
        state_d  = state_q;
        energy_d = energy_q;
        cool_d   = cool_q;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    energy_d = (energy_q >= 8'(FIRE_MAX)) ? 8'(FIRE_MAX) : energy_q + 8'd1;
                    if (fire && (energy_q != 8'd0)) begin
                        state_d = FIRING;
                    end
                end
                FIRING: begin
                    if (!fire) begin
                        state_d = IDLE;
                    end else begin
                        energy_d = energy_q - 8'd1;
                        if (energy_q <= 8'd1) begin
                            energy_d = 8'd0;
                            state_d  = COOLDOWN;
                            cool_d   = CW'(COOL_FRAMES);
                        end
                    end
                end
                COOLDOWN: begin
                    cool_d = cool_q - CW'(1);
                    if (cool_q <= CW'(1)) begin
                        cool_d   = '0;
                        state_d  = IDLE;
                        energy_d = 8'd0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        shooting_d = (state_d == FIRING);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            tick_q     <= '0;
            x_q        <= 10'(START_X);
            y_q        <= 10'(START_Y);
            state_q    <= IDLE;
            energy_q   <= 8'(FIRE_MAX);
            cool_q     <= '0;
            shooting_q <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            tick_q     <= tick_d;
            x_q        <= x_d;
            y_q        <= y_d;
            state_q    <= state_d;
            energy_q   <= energy_d;
            cool_q     <= cool_d;
            shooting_q <= shooting_d;
        end
    end

    assign player_x   = x_q;
    assign player_y   = y_q;
    assign shooting   = shooting_q;
    assign energy     = energy_q;
    assign frame_tick = tick;
endmodule

// File: tb/tb_player_ctrl.sv
// tb_player_ctrl: directed and randomized checks of player_ctrl against a frame-level behavioural model.
// Build with FOCUS_SLOW_EN defined to exercise the slow-step variant.
module tb_player_ctrl;
    localparam int TICK_MAX    = 3;
    localparam int FIRE_MAX    = 4;
    localparam int COOL_FRAMES = 2;
    localparam int START_X     = 192;
    localparam int START_Y     = 400;
    localparam int X_LO        = 8;
    localparam int X_HI        = 375;
    localparam int Y_LO        = 8;
    localparam int Y_HI        = 439;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_up, btn_down, btn_left, btn_right, btn_fire, btn_slow;
    logic [9:0] player_x, player_y;
    logic       shooting;
    logic [7:0] energy;
    logic       frame_tick;

    int         n_checks = 0;
    int         n_fail   = 0;

    int         m_x, m_y, m_energy, m_cool, phase;
    bit         m_firing;
    logic [5:0] hist1, hist2;

    player_ctrl #(
        .TICK_MAX   (TICK_MAX),
        .FIRE_MAX   (FIRE_MAX),
        .COOL_FRAMES(COOL_FRAMES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_fire  (btn_fire),
        .btn_slow  (btn_slow),
        .player_x  (player_x),
        .player_y  (player_y),
        .shooting  (shooting),
        .energy    (energy),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        n_checks++;
        if (observed != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Button vector order: {slow, fire, right, left, down, up}
    task automatic applyStimulus(input logic [5:0] b);
        btn_up    = b[0];
        btn_down  = b[1];
        btn_left  = b[2];
        btn_right = b[3];
        btn_fire  = b[4];
        btn_slow  = b[5];
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    // One frame of game rules applied to the button state seen at that frame's tick.
    function automatic void modelTick(input logic [5:0] b);
        int s;
        s = SPEED_OF(b[5]);
        m_x = clampi(m_x + (b[3] ? s : 0) - (b[2] ? s : 0), X_LO, X_HI);
        m_y = clampi(m_y + (b[1] ? s : 0) - (b[0] ? s : 0), Y_LO, Y_HI);
        if (m_cool > 0) begin
            m_cool--;
        end else if (m_firing) begin
            if (!b[4]) begin
                m_firing = 0;
            end else begin
                m_energy--;
                if (m_energy == 0) begin
                    m_firing = 0;
                    m_cool   = COOL_FRAMES;
                end
            end
        end else begin
            if (b[4] && m_energy > 0) m_firing = 1;
            m_energy = (m_energy + 1 > FIRE_MAX) ? FIRE_MAX : m_energy + 1;
        end
    endfunction

    function automatic int SPEED_OF(input logic slow);
`ifdef FOCUS_SLOW_EN
        return slow ? 2 : 4;
`else
        return (slow === 1'bx) ? 0 : 4;
`endif
    endfunction

    task automatic checkAll();
        checkOutput("frame_tick", int'(frame_tick), (phase == TICK_MAX) ? 1 : 0);
        checkOutput("player_x", int'(player_x), m_x);
        checkOutput("player_y", int'(player_y), m_y);
        checkOutput("shooting", int'(shooting), int'(m_firing));
        checkOutput("energy", int'(energy), m_energy);
    endtask

    // Buttons reach the logic two clocks after they are driven, hence the two-deep history.
    task automatic stepClock();
        if (phase == TICK_MAX) modelTick(hist2);
        hist2 = hist1;
        hist1 = {btn_slow, btn_fire, btn_right, btn_left, btn_down, btn_up};
        phase = (phase == TICK_MAX) ? 0 : phase + 1;
        @(posedge clk);
        #1;
        checkAll();
    endtask

    task automatic doReset(input int cycles);
        reset = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        reset    = 1'b0;
        m_x      = START_X;
        m_y      = START_Y;
        m_energy = FIRE_MAX;
        m_cool   = 0;
        m_firing = 0;
        phase    = 0;
        hist1    = '0;
        hist2    = '0;
        checkOutput("rst_x", int'(player_x), 192);
        checkOutput("rst_y", int'(player_y), 400);
        checkOutput("rst_shooting", int'(shooting), 0);
        checkOutput("rst_energy", int'(energy), 4);
        checkOutput("rst_frame_tick", int'(frame_tick), 0);
    endtask

    task automatic runRandom(input int segments, input int clocks);
        logic [5:0] b;
        int         pref;
        for (int seg = 0; seg < segments; seg++) begin
            pref = $urandom_range(0, 3);
            for (int i = 0; i < clocks; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    b = 6'($urandom);
                    if ($urandom_range(0, 3) != 0) begin
                        b[pref]          = 1'b1;
                        b[pref ^ 1]      = 1'b0;
                    end
                    b[4] = ($urandom_range(0, 9) < 7);
                    applyStimulus(b);
                end
                stepClock();
            end
        end
    endtask

    initial begin
        applyStimulus(6'b000000);
        doReset(2);
        for (int i = 0; i < 12; i++) stepClock();

        // Hold up with slow for three frames.
        doReset(2);
        applyStimulus(6'b100001);
        for (int i = 0; i < 12; i++) stepClock();
`ifdef FOCUS_SLOW_EN
        checkOutput("slow_up_y", int'(player_y), 394);
`else
        checkOutput("slow_up_y", int'(player_y), 388);
`endif

        doReset(2);
        applyStimulus(6'b000100);
        for (int i = 0; i < 60 * 4; i++) stepClock();
        checkOutput("left_clamp_x", int'(player_x), 8);
        applyStimulus(6'b001100);
        for (int i = 0; i < 5 * 4; i++) stepClock();
        checkOutput("both_lr_x", int'(player_x), 8);

        // Exhaust the laser, then reset in the middle of the cooldown.
        doReset(2);
        applyStimulus(6'b010000);
        for (int i = 0; i < 4; i++) stepClock();
        checkOutput("fire_start", int'(shooting), 1);
        for (int i = 0; i < 16; i++) stepClock();
        checkOutput("exhausted_energy", int'(energy), 0);
        checkOutput("cooldown_shooting", int'(shooting), 0);
        for (int i = 0; i < 2; i++) stepClock();
        doReset(1);
        for (int i = 0; i < 8; i++) stepClock();

        doReset(2);
        applyStimulus(6'b010000);
        for (int i = 0; i < 12; i++) stepClock();
        applyStimulus(6'b000000);
        for (int i = 0; i < 4; i++) stepClock();
        checkOutput("release_energy", int'(energy), 2);
        checkOutput("release_shooting", int'(shooting), 0);
        applyStimulus(6'b010000);
        for (int i = 0; i < 4; i++) stepClock();
        checkOutput("repress_shooting", int'(shooting), 1);
        for (int i = 0; i < 60; i++) stepClock();

        doReset(2);
        runRandom(10, 200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
